fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag generator for the async FIFO, on the sending end of the pointer CDC path.
- Keeps the binary write pointer and produces the registered Gray-coded write pointer that the 2-FF synchronizer carries into the read domain.
- Takes the read pointer after it has already been synchronized into the write domain. From it, produces full, almost-full, fill level and a sticky overflow error.
- Runs entirely in the write clock domain.

Parameters:
- ADDR_WIDTH, 3: memory address width. Depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide (4 by default, matching the synchronizer width).
- AFULL_THRESH, 6: fill level at or above which walmost_full asserts. Legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- winc  input  1  write request from the producer.
- rq2_wptr_rd  input  ADDR_WIDTH+1  read pointer, Gray coded, already synchronized into this domain.
- waddr  output  ADDR_WIDTH  RAM write address; equals the low bits of the binary write pointer.
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the synchronizer.
- wen  output  1  RAM write enable, defined as winc && !wfull (combinational).
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  fill level >= AFULL_THRESH, registered.
- wlevel  output  ADDR_WIDTH+1  fill level as seen from the write side, registered, range 0..2**ADDR_WIDTH.
- woverflow  output  1  sticky error: a write was attempted while full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wbin, wptr, wfull, walmost_full, wlevel and woverflow all clear to 0; waddr=0 as a consequence.
  - winc is ignored while rst=1, and rst has priority over every other event.
  - Reset mid-operation discards all state; there is no partial recovery.
- Write acceptance:
  - A write is accepted when winc=1 and wfull=0 (same condition as wen).
  - wbin_next = wbin + acc, with modulo 2**(ADDR_WIDTH+1) wrap.
  - waddr presents the current slot, so data is written in the same cycle winc is accepted.
- Gray pointer:
  - wgray_next = (wbin_next >> 1) ^ wbin_next; wptr <= wgray_next.
  - wptr is driven directly from a flop with no combinational logic on the output, so exactly one bit changes per accepted write.
  - Latency from an accepted winc to the wptr update is 1 cycle.
- Full:
  - wfull <= (wgray_next == {~rq2_wptr_rd[MSB:MSB-1], rq2_wptr_rd[MSB-2:0]}).
  - wfull asserts on the same edge that commits the write filling the last slot.
- Level:
  - rbin_s is the Gray-to-binary conversion of rq2_wptr_rd (XOR prefix from the MSB).
  - wlevel <= wbin_next - rbin_s, computed modulo 2**(ADDR_WIDTH+1).
  - walmost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
- Overflow: woverflow <= woverflow | (winc & wfull). Only rst clears it. The pointer does not move on an overflow attempt.
- Stale read pointer:
  - The synchronized read pointer lags the true read pointer, so wfull and wlevel are pessimistic (may report fuller than actual), never optimistic.
  - wfull deasserts one cycle after rq2_wptr_rd advances.
- Simultaneous events: an accepted winc and a change on rq2_wptr_rd in the same cycle are both reflected in that edge's update of wfull, wlevel and walmost_full.
- Wrap-around:
  - waddr wraps from 2**ADDR_WIDTH-1 to 0.
  - The pointer MSB toggles once per pass through the memory, which lets full be distinguished from empty.
- Assertions required:
  - wptr changes in at most 1 bit per cycle.
  - wlevel <= 2**ADDR_WIDTH at all times.
  - wen is never 1 while wfull is 1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with winc=1 -> wptr=0000, waddr=0, wfull=0, wlevel=0, walmost_full=0, woverflow=0.
- Fill from empty: rq2_wptr_rd=0000, 8 consecutive winc pulses -> wptr steps through 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100. walmost_full=1 after the 6th write; wfull=1 and wlevel=8 after the 8th.
- Overflow: FIFO full, winc=1 for 2 cycles -> wptr holds 1100, wen=0, woverflow=1 from the next edge. After winc=0, woverflow stays 1 until rst.
- Drain seen from write side: FIFO full, rq2_wptr_rd set to 0100 (binary 7) -> next edge wfull=0, wlevel=1, walmost_full=0. A following winc is accepted at waddr=0.
- Wrap-around: 16 writes with rq2_wptr_rd tracking 1 write behind -> waddr runs 0..7, 0..7. wptr returns to 0000 with the MSB toggling at the 8th and 16th writes. wfull stays 0 throughout.
- Reset mid-operation: wfull=1, woverflow=1, pulse rst=1 for 1 cycle -> all outputs 0 on that edge. The next accepted winc produces wptr=0001.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/level generator for the async FIFO.
// Holds the binary write pointer, publishes a registered Gray pointer for
// the read-domain synchronizer, and derives full, almost-full, fill level
// and a sticky overflow flag from the already-synchronized read pointer.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr_rd,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wen,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int                PW      = ADDR_WIDTH + 1;
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0]     AFULL_P = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // XOR prefix from the MSB down.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_p1;
  logic          acc_p0;
  logic [PW-1:0] wbin_p0;
  logic [PW-1:0] wgray_p0;
  logic [PW-1:0] rbin_p0;
  logic [PW-1:0] level_p0;
  logic          full_p0;
  logic          afull_p0;

  assign acc_p0 = winc && !wfull;
  assign wen    = acc_p0;
  assign waddr  = wbin_p1[ADDR_WIDTH-1:0];

  // ---- stage p0: next pointer and flags from current state + sync'd rptr
  always_comb begin
    wbin_p0  = wbin_p1 + {{(PW-1){1'b0}}, acc_p0};
    wgray_p0 = bin2gray(wbin_p0);
    rbin_p0  = gray2bin(rq2_wptr_rd);
    level_p0 = wbin_p0 - rbin_p0;
    // Full when the pointers match except for the two MSBs, which in Gray
    // code both flip after exactly one lap of the memory.
    full_p0  = (wgray_p0 == {~rq2_wptr_rd[PW-1:PW-2], rq2_wptr_rd[PW-3:0]});
    afull_p0 = (level_p0 >= AFULL_P);
  end

  // ---- stage p1: registered pointer, Gray output and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_p1      <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin_p1      <= wbin_p0;
      wptr         <= wgray_p0;
      wfull        <= full_p0;
      walmost_full <= afull_p0;
      wlevel       <= level_p0;
      woverflow    <= woverflow | (winc & wfull);
    end
  end

  a_wptr_one_bit : assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> ($countones(wptr ^ $past(wptr)) <= 1));

  a_level_bound : assert property (@(posedge clk) disable iff (rst)
    wlevel <= PW'(DEPTH));

  a_no_wen_full : assert property (@(posedge clk) !(wen && wfull));

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: count-based reference model feeding a
// scoreboard, plus fixed-value checks taken from the expected sequences.
module tb_fifo_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [3:0] rq2;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wen;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rq2_wptr_rd  (rq2),
    .waddr        (waddr),
    .wptr         (wptr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       full;
    logic       afull;
    logic       ovf;
    logic [3:0] lvl;
  } exp_t;

  exp_t sb[$];

  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  int   n_vec = 0;
  int   n_err = 0;
  int   m_wr  = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  // One clock of stimulus: drive at negedge, check wen/waddr before the
  // edge, push model expectation, pop and compare after the edge.
  task automatic step(input logic i_rst, input logic i_winc, input int i_rd,
                      input string tag);
    exp_t e;
    logic acc;
    int   lvl;
    @(negedge clk);
    rst  = i_rst;
    winc = i_winc;
    rq2  = gtab[i_rd % 16];
    #1;
    n_vec++;
    if (wen !== (i_winc && !m_full)) begin
      n_err++;
      $display("FAIL %s wen: got %b want %b", tag, wen, i_winc && !m_full);
    end
    n_vec++;
    if (waddr !== 3'(m_wr % 8)) begin
      n_err++;
      $display("FAIL %s waddr_pre: got %0d want %0d", tag, waddr, m_wr % 8);
    end
    acc = i_winc && !m_full;
    if (i_rst) begin
      m_wr   = 0;
      m_ovf  = 1'b0;
      m_full = 1'b0;
      lvl    = 0;
    end else begin
      m_ovf = m_ovf | (i_winc & m_full);
      if (acc) m_wr++;
      lvl    = m_wr - i_rd;
      m_full = (lvl == 8);
    end
    e.wptr  = gtab[m_wr % 16];
    e.waddr = 3'(m_wr % 8);
    e.full  = m_full;
    e.afull = (lvl >= 6);
    e.ovf   = m_ovf;
    e.lvl   = 4'(lvl);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (wptr !== e.wptr) begin
      n_err++; $display("FAIL %s wptr: got %b want %b", tag, wptr, e.wptr);
    end
    n_vec++;
    if (waddr !== e.waddr) begin
      n_err++; $display("FAIL %s waddr: got %0d want %0d", tag, waddr, e.waddr);
    end
    n_vec++;
    if (wfull !== e.full) begin
      n_err++; $display("FAIL %s wfull: got %b want %b", tag, wfull, e.full);
    end
    n_vec++;
    if (walmost_full !== e.afull) begin
      n_err++; $display("FAIL %s walmost_full: got %b want %b", tag, walmost_full, e.afull);
    end
    n_vec++;
    if (woverflow !== e.ovf) begin
      n_err++; $display("FAIL %s woverflow: got %b want %b", tag, woverflow, e.ovf);
    end
    n_vec++;
    if (wlevel !== e.lvl) begin
      n_err++; $display("FAIL %s wlevel: got %0d want %0d", tag, wlevel, e.lvl);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 0, "reset0");
    step(1'b1, 1'b1, 0, "reset1");
    n_vec++;
    if ({wptr, waddr, wfull, wlevel, walmost_full, woverflow} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_all: got wptr=%b waddr=%0d full=%b lvl=%0d af=%b ovf=%b want all 0",
               wptr, waddr, wfull, wlevel, walmost_full, woverflow);
    end
  endtask

  task automatic test_fill();
    logic [3:0] seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 0, "fill");
      n_vec++;
      if (wptr !== seq[i]) begin
        n_err++; $display("FAIL fill_seq%0d: got %b want %b", i, wptr, seq[i]);
      end
      n_vec++;
      if (walmost_full !== (i >= 5)) begin
        n_err++; $display("FAIL fill_afull%0d: got %b want %b", i, walmost_full, i >= 5);
      end
      n_vec++;
      if (wfull !== (i == 7)) begin
        n_err++; $display("FAIL fill_full%0d: got %b want %b", i, wfull, i == 7);
      end
    end
    n_vec++;
    if (wlevel !== 4'd8) begin
      n_err++; $display("FAIL fill_level: got %0d want 8", wlevel);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 0, "ovf");
      n_vec++;
      if (wptr !== 4'b1100 || woverflow !== 1'b1) begin
        n_err++; $display("FAIL ovf_hold%0d: got wptr=%b ovf=%b want 1100 1", i, wptr, woverflow);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 0, "ovf_idle");
      n_vec++;
      if (woverflow !== 1'b1) begin
        n_err++; $display("FAIL ovf_sticky%0d: got %b want 1", i, woverflow);
      end
    end
  endtask

  task automatic test_drain();
    step(1'b0, 1'b0, 7, "drain");
    n_vec++;
    if (wfull !== 1'b0 || wlevel !== 4'd1 || walmost_full !== 1'b0) begin
      n_err++;
      $display("FAIL drain_flags: got full=%b lvl=%0d af=%b want 0 1 0", wfull, wlevel, walmost_full);
    end
  endtask

  // Accepted write and read-pointer advance land on the same edge.
  task automatic test_back_to_back();
    step(1'b0, 1'b1, 8, "b2b");
    n_vec++;
    if (wlevel !== 4'd1 || wptr !== 4'b1101 || waddr !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_level: got lvl=%0d wptr=%b waddr=%0d want 1 1101 1", wlevel, wptr, waddr);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 0, "wrap_rst");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, i, "wrap");
      n_vec++;
      if (wptr[3] !== (i >= 7 && i < 15) || wfull !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_msb%0d: got msb=%b full=%b want %b 0", i, wptr[3], wfull, i >= 7 && i < 15);
      end
    end
    n_vec++;
    if (wptr !== 4'b0000 || waddr !== 3'd0) begin
      n_err++; $display("FAIL wrap_end: got wptr=%b waddr=%0d want 0000 0", wptr, waddr);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 0, "mid_rst0");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 0, "mid_fill");
    n_vec++;
    if (wfull !== 1'b1 || woverflow !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got full=%b ovf=%b want 1 1", wfull, woverflow);
    end
    step(1'b1, 1'b1, 0, "mid_rst");
    n_vec++;
    if ({wptr, waddr, wfull, wlevel, walmost_full, woverflow} !== 14'd0) begin
      n_err++; $display("FAIL mid_clear: got wptr=%b full=%b ovf=%b want 0", wptr, wfull, woverflow);
    end
    step(1'b0, 1'b1, 0, "mid_after");
    n_vec++;
    if (wptr !== 4'b0001) begin
      n_err++; $display("FAIL mid_first: got %b want 0001", wptr);
    end
  endtask

  initial begin
    rst  = 1'b1;
    winc = 1'b0;
    rq2  = 4'd0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
